// File: rtl/register_file.sv
// register_file: four-entry, DATA_WIDTH-bit register file for the 2-bit-addressed
// CPU datapath. Writes are staged through a one-entry writeback latch before they
// reach the array. Both read ports are combinational and bypass the incoming write
// and the latch, so a write can be read back in the cycle it is accepted.
module register_file #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Clear,
  input  logic                  RegWrite,
  input  logic [1:0]            Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Write_Ready,
  input  logic                  Stall,
  input  logic [1:0]            Read_Register1,
  input  logic [1:0]            Read_Register2,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  output logic [3:0]            Pending,
  output logic [7:0]            Write_Count
);

  // Register array and writeback latch.
  logic [DATA_WIDTH-1:0] regs [4];
  logic                  wb_valid;
  logic [1:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  // Handshake terms for the current cycle.
  logic accept;
  logic commit;

  // One read port: incoming accepted write wins, then the latch, then the array.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [1:0]            idx,
    input logic                  acc,
    input logic [1:0]            w_addr,
    input logic [DATA_WIDTH-1:0] w_data,
    input logic                  l_valid,
    input logic [1:0]            l_addr,
    input logic [DATA_WIDTH-1:0] l_data,
    input logic [DATA_WIDTH-1:0] arr_val
  );
    if (acc && (w_addr == idx)) begin
      return w_data;
    end else if (l_valid && (l_addr == idx)) begin
      return l_data;
    end else begin
      return arr_val;
    end
  endfunction

  // The latch can take a new write unless it is full and held by Stall.
  // NOTE: every output of an always_comb is assigned on every path (here
  // unconditionally), so no latch is inferred.
  always_comb begin
    Write_Ready = !(wb_valid && Stall);
    accept      = RegWrite && Write_Ready;
    commit      = wb_valid && !Stall;
  end

  // Bypassed combinational reads; Clear does not affect them until its edge.
  always_comb begin
    Read_Data1 = read_port(Read_Register1, accept, Write_Register, Write_Data,
                           wb_valid, wb_addr, wb_data, regs[Read_Register1]);
    Read_Data2 = read_port(Read_Register2, accept, Write_Register, Write_Data,
                           wb_valid, wb_addr, wb_data, regs[Read_Register2]);
  end

  // One-hot mask of the index waiting in the latch.
  always_comb begin
    Pending = wb_valid ? (4'b0001 << wb_addr) : 4'b0000;
  end

  // Writeback latch: Clear empties it; otherwise an accept reloads it (even on a
  // commit edge) and a commit without an accept empties it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= 2'd0;
      wb_data  <= '0;
    end else if (Clear) begin
      wb_valid <= 1'b0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_addr  <= Write_Register;
      wb_data  <= Write_Data;
    end else if (commit) begin
      wb_valid <= 1'b0;
    end
  end

  // Register array: committed latch contents land here; reset and Clear zero it.
  // NOTE: the array is only four words, and a known-zero state after reset is
  // architecturally visible, so it lives in resettable flops rather than a RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (Clear) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Committed-write counter, wrapping modulo 256.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Write_Count <= 8'd0;
    end else if (Clear) begin
      Write_Count <= 8'd0;
    end else if (commit) begin
      Write_Count <= Write_Count + 8'd1;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed stimulus for register_file. A queue-based model of
// the architectural state is checked against the DUT every falling edge, and the
// driver adds hand-computed literal checks at the key points of each scenario.
module tb_register_file;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Clear;
  logic          RegWrite;
  logic [1:0]    Write_Register;
  logic [DW-1:0] Write_Data;
  logic          Write_Ready;
  logic          Stall;
  logic [1:0]    Read_Register1;
  logic [1:0]    Read_Register2;
  logic [DW-1:0] Read_Data1;
  logic [DW-1:0] Read_Data2;
  logic [3:0]    Pending;
  logic [7:0]    Write_Count;

  register_file #(.DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .RegWrite(RegWrite),
    .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Write_Ready(Write_Ready), .Stall(Stall),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .Pending(Pending), .Write_Count(Write_Count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pending write is a queue of at most one (index, value) pair waiting to
  // reach the array; the array and commit count are plain variables.
  typedef struct {
    logic [1:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] m_regs [4];
  wr_t           m_q [$];
  int            m_count;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_q.delete();
    m_count = 0;
  endfunction

  function automatic logic m_ready();
    return !((m_q.size() != 0) && Stall);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [1:0] idx);
    if (RegWrite && m_ready() && (Write_Register == idx)) return Write_Data;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].addr == idx) return m_q[i].data;
    return m_regs[idx];
  endfunction

  function automatic void model_edge();
    logic acc;
    acc = RegWrite && m_ready();
    if (Clear) begin
      model_reset();
      return;
    end
    if ((m_q.size() != 0) && !Stall) begin
      wr_t w;
      w = m_q.pop_front();
      m_regs[w.addr] = w.data;
      m_count = (m_count + 1) % 256;
    end
    if (acc) m_q.push_back('{addr: Write_Register, data: Write_Data});
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge Clk);
      if (!Reset_n) model_reset();
      check("model_queue_depth", m_q.size(), (m_q.size() > 1) ? 32'd1 : m_q.size());
      check("cmp_write_ready", Write_Ready, m_ready());
      check("cmp_pending", Pending,
            (m_q.size() != 0) ? (32'd1 << m_q[0].addr) : 32'd0);
      check("cmp_write_count", Write_Count, m_count);
      check("cmp_read_data1", Read_Data1, m_read(Read_Register1));
      check("cmp_read_data2", Read_Data2, m_read(Read_Register2));
      @(posedge Clk);
      if (!Reset_n) model_reset();
      else model_edge();
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [1:0] addr,
                           input logic [DW-1:0] data);
    RegWrite       = en;
    Write_Register = addr;
    Write_Data     = data;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      Read_Register1 = 2'(i);
      Read_Register2 = 2'(3 - i);
      #1;
      check({tag, "_rd1"}, Read_Data1, 32'h0);
      check({tag, "_rd2"}, Read_Data2, 32'h0);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Clear = 1'b0;
    Stall = 1'b0;
    Read_Register1 = 2'd0;
    Read_Register2 = 2'd0;
    set_write(1'b0, 2'd0, '0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    // Reset state.
    check_all_zero("reset");
    check("reset_pending", Pending, 32'h0);
    check("reset_ready", Write_Ready, 32'h1);
    check("reset_count", Write_Count, 32'h0);

    // Write R2=0x1234, visible in cycles 0, 1, 2.
    Read_Register1 = 2'd2;
    set_write(1'b1, 2'd2, 16'h1234);
    #1;
    check("wr2_cyc0_rd1", Read_Data1, 32'h1234);
    check("wr2_cyc0_pending", Pending, 32'h0);
    tick();
    set_write(1'b0, 2'd0, '0);
    #1;
    check("wr2_cyc1_rd1", Read_Data1, 32'h1234);
    check("wr2_cyc1_pending", Pending, 32'h4);
    check("wr2_cyc1_count", Write_Count, 32'h0);
    tick();
    check("wr2_cyc2_rd1", Read_Data1, 32'h1234);
    check("wr2_cyc2_pending", Pending, 32'h0);
    check("wr2_cyc2_count", Write_Count, 32'h1);

    // Write R1=0xAAAA, then stall 3 cycles while R3=0x5555 is requested.
    set_write(1'b1, 2'd1, 16'hAAAA);
    tick();
    Stall = 1'b1;
    set_write(1'b1, 2'd3, 16'h5555);
    Read_Register1 = 2'd1;
    Read_Register2 = 2'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", Write_Ready, 32'h0);
      check("stall_pending", Pending, 32'h2);
      check("stall_rd1", Read_Data1, 32'hAAAA);
      check("stall_rd2_not_accepted", Read_Data2, 32'h0);
      check("stall_count", Write_Count, 32'h1);
      tick();
    end
    Stall = 1'b0;
    #1;
    check("unstall_ready", Write_Ready, 32'h1);
    check("unstall_rd2_bypass", Read_Data2, 32'h5555);
    tick();
    set_write(1'b0, 2'd0, '0);
    #1;
    check("r1_commit_count", Write_Count, 32'h2);
    check("r3_pending", Pending, 32'h8);
    check("r1_array", Read_Data1, 32'hAAAA);
    tick();
    check("r3_commit_count", Write_Count, 32'h3);
    check("r3_commit_pending", Pending, 32'h0);
    check("r3_array", Read_Data2, 32'h5555);

    // Same-index overwrite: latch holds R0=0x1111, new write R0=0x00FF.
    Read_Register1 = 2'd0;
    set_write(1'b1, 2'd0, 16'h1111);
    tick();
    set_write(1'b1, 2'd0, 16'h00FF);
    #1;
    check("r0_youngest", Read_Data1, 32'h00FF);
    tick();
    set_write(1'b0, 2'd0, '0);
    tick();
    check("r0_final", Read_Data1, 32'h00FF);
    check("r0_count", Write_Count, 32'h5);

    // Clear while latch holds R2=0xBEEF and R3=0x0001 is requested.
    set_write(1'b1, 2'd2, 16'hBEEF);
    tick();
    set_write(1'b1, 2'd3, 16'h0001);
    Clear = 1'b1;
    Read_Register1 = 2'd2;
    Read_Register2 = 2'd3;
    #1;
    check("clear_pre_rd1", Read_Data1, 32'hBEEF);
    check("clear_pre_rd2", Read_Data2, 32'h0001);
    check("clear_pre_ready", Write_Ready, 32'h1);
    tick();
    Clear = 1'b0;
    set_write(1'b0, 2'd0, '0);
    check_all_zero("clear");
    check("clear_pending", Pending, 32'h0);
    check("clear_count", Write_Count, 32'h0);
    tick();
    check_all_zero("clear_later");
    check("clear_later_count", Write_Count, 32'h0);

    // 256 back-to-back writes: counter reaches 255 then wraps to 0.
    for (int i = 0; i < 256; i++) begin
      set_write(1'b1, 2'(i), 16'(i * 16'h0101));
      Read_Register1 = 2'(i);
      Read_Register2 = 2'(i + 1);
      tick();
    end
    check("wrap_255", Write_Count, 32'hFF);
    set_write(1'b0, 2'd0, '0);
    tick();
    check("wrap_0", Write_Count, 32'h0);
    Read_Register1 = 2'd3;
    #1;
    check("wrap_r3", Read_Data1, 32'hFFFF);

    // Reset mid-stall drops the latched write.
    set_write(1'b1, 2'd1, 16'h7777);
    tick();
    set_write(1'b0, 2'd0, '0);
    Stall = 1'b1;
    tick();
    check("midstall_pending", Pending, 32'h2);
    Reset_n = 1'b0;
    #1;
    check("midstall_rst_pending", Pending, 32'h0);
    check("midstall_rst_ready", Write_Ready, 32'h1);
    check("midstall_rst_count", Write_Count, 32'h0);
    tick();
    Reset_n = 1'b1;
    Stall = 1'b0;
    tick();
    tick();
    check_all_zero("midstall_after");
    check("midstall_after_count", Write_Count, 32'h0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
